// File: rtl/spi_slave.sv
// SPI slave clocked directly by SCLK: deserialises 2-bit-command frames from MOSI
// and, after a read-data command, serialises one word from the memory onto MISO.
module spi_slave #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST_RX = CNT_W'(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST_TX = CNT_W'(DATA_W - 1);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CHK_CMD   = 4'd1,
        WRITE     = 4'd2,
        READ_ADD  = 4'd3,
        READ_DATA = 4'd4,
        TX_GAP    = 4'd5,
        WAIT_TX   = 4'd6,
        SEND      = 4'd7,
        HOLD      = 4'd8
    } state_t;

    state_t                state_r,        state_s;
    logic [CNT_W-1:0]      cnt_r,          cnt_s;
    logic [DATA_W:0]       rx_shift_r,     rx_shift_s;
    logic [DATA_W-1:0]     tx_shift_r,     tx_shift_s;
    logic                  miso_r,         miso_s;
    logic [DATA_W+1:0]     rx_data_r,      rx_data_s;
    logic                  rx_valid_r,     rx_valid_s;
    logic                  rd_addr_seen_r, rd_addr_seen_s;
    logic [DATA_W+1:0]     frame_s;

    function automatic logic [1:0] frame_cmd(input logic [DATA_W+1:0] frame);
        return frame[DATA_W+1:DATA_W];
    endfunction

    // The read-address flag survives SS_n deassertion; only a completed frame moves it.
    function automatic logic next_rd_addr_seen(input logic [1:0] cmd, input logic cur);
        logic nxt;
        case (cmd)
            CMD_RD_ADDR: nxt = 1'b1;
            CMD_RD_DATA: nxt = 1'b0;
            CMD_WR_ADDR: nxt = cur;
            CMD_WR_DATA: nxt = cur;
            default:     nxt = cur;
        endcase
        return nxt;
    endfunction

    // State, counter, shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            rx_shift_r     <= {(DATA_W+1){1'b0}};
            tx_shift_r     <= {DATA_W{1'b0}};
            miso_r         <= 1'b0;
            rx_data_r      <= {(DATA_W+2){1'b0}};
            rx_valid_r     <= 1'b0;
            rd_addr_seen_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            rx_shift_r     <= rx_shift_s;
            tx_shift_r     <= tx_shift_s;
            miso_r         <= miso_s;
            rx_data_r      <= rx_data_s;
            rx_valid_r     <= rx_valid_s;
            rd_addr_seen_r <= rd_addr_seen_s;
        end
    end

    // Next-state and next-output decode; SS_n high outside IDLE overrides everything.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        rx_shift_s     = rx_shift_r;
        tx_shift_s     = tx_shift_r;
        miso_s         = 1'b0;
        rx_data_s      = rx_data_r;
        rx_valid_s     = 1'b0;
        rd_addr_seen_s = rd_addr_seen_r;
        frame_s        = {rx_shift_r, MOSI};

        if ((state_r != IDLE) && SS_n) begin
            state_s    = IDLE;
            cnt_s      = CNT_ZERO;
            rx_shift_s = {(DATA_W+1){1'b0}};
            tx_shift_s = {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_s = CNT_ZERO;
                    if (!SS_n) begin
                        state_s = CHK_CMD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                CHK_CMD: begin
                    rx_shift_s = {rx_shift_r[DATA_W-1:0], MOSI};
                    cnt_s      = CNT_ONE;
                    if (!MOSI) begin
                        state_s = WRITE;
                    end else if (rd_addr_seen_r) begin
                        state_s = READ_DATA;
                    end else begin
                        state_s = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (cnt_r == CNT_LAST_RX) begin
                        rx_data_s      = frame_s;
                        rx_valid_s     = 1'b1;
                        cnt_s          = CNT_ZERO;
                        rx_shift_s     = {(DATA_W+1){1'b0}};
                        rd_addr_seen_s = next_rd_addr_seen(frame_cmd(frame_s), rd_addr_seen_r);
                        if (frame_cmd(frame_s) == CMD_RD_DATA) begin
                            state_s = TX_GAP;
                        end else begin
                            state_s = HOLD;
                        end
                    end else begin
                        rx_shift_s = {rx_shift_r[DATA_W-1:0], MOSI};
                        cnt_s      = cnt_r + CNT_ONE;
                    end
                end
                // One dead cycle so a tx_valid left over from before the frame is never taken.
                TX_GAP: begin
                    state_s = WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        tx_shift_s = {tx_data[DATA_W-2:0], 1'b0};
                        miso_s     = tx_data[DATA_W-1];
                        cnt_s      = CNT_ZERO;
                        state_s    = SEND;
                    end else begin
                        state_s = WAIT_TX;
                    end
                end
                SEND: begin
                    if (cnt_r == CNT_LAST_TX) begin
                        cnt_s      = CNT_ZERO;
                        tx_shift_s = {DATA_W{1'b0}};
                        state_s    = HOLD;
                    end else begin
                        miso_s     = tx_shift_r[DATA_W-1];
                        tx_shift_s = {tx_shift_r[DATA_W-2:0], 1'b0};
                        cnt_s      = cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    state_s = HOLD;
                end
                default: begin
                    state_s    = IDLE;
                    cnt_s      = CNT_ZERO;
                    rx_shift_s = {(DATA_W+1){1'b0}};
                    tx_shift_s = {DATA_W{1'b0}};
                end
            endcase
        end
    end

    assign MISO     = miso_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: expected frames and MISO bits are queued as
// stimulus is driven and popped as the slave produces rx_valid / MISO output.
module tb_spi_slave;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SS_n;
    logic          MOSI;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          MISO;
    logic [DW+1:0] rx_data;
    logic          rx_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW+1:0] exp_rx_q[$];
    logic          exp_miso_q[$];

    spi_slave #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every rx_valid strobe must match the oldest queued frame; a stray one sees a sentinel.
    always @(negedge clk) begin : rx_monitor
        logic [31:0] exp_v;
        if (rst_n === 1'b1 && rx_valid === 1'b1) begin
            exp_v = (exp_rx_q.size() > 0) ? 32'(exp_rx_q.pop_front()) : 32'hFFFF_FFFF;
            check_eq("rx_data", 32'(rx_data), exp_v);
        end
    end

    task automatic send_frame(input logic [DW+1:0] bits, input bit ss_on_last);
        if (!ss_on_last) exp_rx_q.push_back(bits);
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        for (int i = DW + 1; i >= 0; i--) begin
            MOSI = bits[i];
            if (i == 0 && ss_on_last) SS_n = 1'b1;
            tick();
            check_eq("miso_frame", 32'(MISO), 32'd0);
        end
    endtask

    task automatic end_txn();
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        check_eq("state_idle", 32'(dut.state_r), 32'd0);
        check_eq("miso_idle", 32'(MISO), 32'd0);
    endtask

    // Called at E0+1 of a read-data frame; tx_valid raised after E1 plus gap cycles.
    task automatic read_tx(input logic [DW-1:0] data, input int gap);
        tick();
        check_eq("miso_gap", 32'(MISO), 32'd0);
        for (int w = 0; w < gap; w++) begin
            tick();
            check_eq("miso_wait", 32'(MISO), 32'd0);
        end
        tx_data  = data;
        tx_valid = 1'b1;
        for (int b = DW - 1; b >= 0; b--) exp_miso_q.push_back(data[b]);
        exp_miso_q.push_back(1'b0);
        tick();
        for (int k = 0; k <= DW; k++) begin
            if (k > 0) tick();
            check_eq("miso_bit", 32'(MISO), 32'(exp_miso_q.pop_front()));
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        tick();
        tick();
        check_eq("rst_miso", 32'(MISO), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_state", 32'(dut.state_r), 32'd0);
        check_eq("rst_rd_addr", 32'(dut.rd_addr_seen_r), 32'd0);
        rst_n = 1'b1;
        tick();

        // Write address, then MOSI toggling in HOLD must not produce anything.
        send_frame(10'h08B, 1'b0);
        for (int h = 0; h < 12; h++) begin
            MOSI = h[0];
            tick();
            check_eq("miso_hold", 32'(MISO), 32'd0);
        end
        check_eq("rx_hold", 32'(rx_data), 32'h08B);
        end_txn();

        // Write data.
        send_frame(10'h1B6, 1'b0);
        end_txn();

        // Read address then read data with tx_valid from E1.
        send_frame(10'h20F, 1'b0);
        check_eq("rd_addr_set", 32'(dut.rd_addr_seen_r), 32'd1);
        end_txn();
        check_eq("rd_addr_keep", 32'(dut.rd_addr_seen_r), 32'd1);
        send_frame(10'h30F, 1'b0);
        read_tx(8'hA5, 0);
        check_eq("rd_addr_clr", 32'(dut.rd_addr_seen_r), 32'd0);
        end_txn();

        // Read with late tx_valid and random payload.
        send_frame(10'h2C4, 1'b0);
        end_txn();
        send_frame(10'h35A, 1'b0);
        read_tx(DW'($urandom_range(0, 255)), 3);
        end_txn();

        // Sticky tx_valid with stale data must not be consumed.
        send_frame(10'h255, 1'b0);
        end_txn();
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        send_frame(10'h3F0, 1'b0);
        read_tx(8'h3C, 0);
        end_txn();

        // Abort after 5 bits, then a full frame.
        SS_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'b1;
            tick();
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        check_eq("abort_state", 32'(dut.state_r), 32'd0);
        send_frame(10'h001, 1'b0);
        end_txn();

        // SS_n rising with the last bit discards the frame.
        send_frame(10'h155, 1'b1);
        check_eq("ss_last_state", 32'(dut.state_r), 32'd0);
        tick();
        check_eq("ss_last_rx", 32'(rx_data), 32'h001);

        // Reset mid-frame with rd_addr_seen set.
        send_frame(10'h233, 1'b0);
        end_txn();
        SS_n = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            MOSI = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstf_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rstf_state", 32'(dut.state_r), 32'd0);
        check_eq("rstf_rd_addr", 32'(dut.rd_addr_seen_r), 32'd0);
        check_eq("rstf_rx_data", 32'(rx_data), 32'd0);
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset after three MISO bits.
        send_frame(10'h2AA, 1'b0);
        end_txn();
        send_frame(10'h3C3, 1'b0);
        tick();
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        check_eq("send_b7", 32'(MISO), 32'd1);
        tick();
        check_eq("send_b6", 32'(MISO), 32'd0);
        tick();
        check_eq("send_b5", 32'(MISO), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rsts_miso", 32'(MISO), 32'd0);
        check_eq("rsts_state", 32'(dut.state_r), 32'd0);
        check_eq("rsts_rd_addr", 32'(dut.rd_addr_seen_r), 32'd0);
        SS_n = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("post_rst_miso", 32'(MISO), 32'd0);
        end
        tx_valid = 1'b0;

        check_eq("rx_q_empty", 32'(exp_rx_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
